// File: rtl/audio_clip_player_if.sv
// Bus between audio_clip_player, the clip ROM, the audio controller FIFO and the host.
// master = player side, slave = environment side.
interface audio_clip_player_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 6
);
  logic              play_req;
  logic [1:0]        clip_sel;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [31:0]       left_channel_audio_out;
  logic [31:0]       right_channel_audio_out;
  logic              busy;
  logic              done;

  modport master (
    input  play_req, clip_sel, stop, rom_q, audio_out_allowed,
    output rom_addr, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, busy, done
  );

  modport slave (
    output play_req, clip_sel, stop, rom_q, audio_out_allowed,
    input  rom_addr, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, busy, done
  );
endinterface

// File: rtl/audio_clip_player.sv
// Stall-aware clip sequencer: walks a clip's ROM range and pushes one sample per DIV cycles.
// Define CLIP_LOOP_EN to replay the clip continuously instead of stopping after one pass.
module audio_clip_player #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 6,
  parameter int DIV         = 2000,
  parameter int CLIP0_START = 0,
  parameter int CLIP0_END   = 27100,
  parameter int CLIP1_START = 27101,
  parameter int CLIP1_END   = 43830,
  parameter int CLIP2_START = 43831,
  parameter int CLIP2_END   = 54300
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  audio_clip_player_if.master bus
);
  localparam int              CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PUSH, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_end, r_start;
  logic [DATA_W-1:0] r_sample;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] w_clip_start, w_clip_end;
  logic              w_valid_req, w_load, w_inc, w_rewind, w_write, w_done;

  always_comb begin
    case (bus.clip_sel)
      2'd1:    begin w_clip_start = ADDR_W'(CLIP1_START); w_clip_end = ADDR_W'(CLIP1_END); end
      2'd2:    begin w_clip_start = ADDR_W'(CLIP2_START); w_clip_end = ADDR_W'(CLIP2_END); end
      default: begin w_clip_start = ADDR_W'(CLIP0_START); w_clip_end = ADDR_W'(CLIP0_END); end
    endcase
  end

  assign w_valid_req = bus.play_req && (bus.clip_sel != 2'd3);

  // Next state; stop beats a simultaneous request, a request beats everything else
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_rewind    = 1'b0;
    w_write     = 1'b0;
    w_done      = 1'b0;
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_valid_req) begin
      w_state_nxt = S_FETCH;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: w_state_nxt = S_LATCH;
        S_LATCH: w_state_nxt = S_PUSH;
        S_PUSH: begin
          if (bus.audio_out_allowed) begin
            w_write     = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt >= CNT_MAX) begin
            if (r_addr != r_end) begin
              w_inc       = 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_done = 1'b1;
`ifdef CLIP_LOOP_EN
              w_rewind    = 1'b1;
              w_state_nxt = S_FETCH;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Address, sample and interval counter
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_end    <= '0;
      r_start  <= '0;
      r_sample <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_load) begin
        r_addr  <= w_clip_start;
        r_end   <= w_clip_end;
        r_start <= w_clip_start;
      end else if (w_inc) begin
        r_addr <= r_addr + 1'b1;
      end else if (w_rewind) begin
        r_addr <= r_start;
      end
      if (r_state == S_LATCH && w_state_nxt == S_PUSH) r_sample <= bus.rom_q;
      if (w_state_nxt == S_FETCH)                          r_cnt <= '0;
      else if (r_state != S_IDLE && r_cnt != CNT_MAX)      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.rom_addr                = r_addr;
  assign bus.write_audio_out         = w_write;
  assign bus.done                    = w_done;
  assign bus.busy                    = (r_state != S_IDLE);
  assign bus.left_channel_audio_out  = 32'(r_sample) << (32 - DATA_W);
  assign bus.right_channel_audio_out = 32'd0;
endmodule

// File: tb/tb_audio_clip_player.sv
// Directed self-checking bench for audio_clip_player (DIV=4, short clips, ROM word = address+1).
// Expectations for CLIP_LOOP_EN follow the same macro.
module tb_audio_clip_player;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 6;
  localparam int DIV    = 4;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  audio_clip_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  audio_clip_player #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV(DIV),
    .CLIP0_START(0),  .CLIP0_END(3),
    .CLIP1_START(20), .CLIP1_END(29),
    .CLIP2_START(8),  .CLIP2_END(9)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) bus.rom_q <= DATA_W'(bus.rom_addr + 16'd1);

  function automatic logic [31:0] smp(input int v);
    return 32'(v) << (32 - DATA_W);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs apply to the cycle that begins at this posedge; outputs are sampled at the negedge.
  task automatic cyc(input logic pr, input logic [1:0] cs, input logic st,
                     input logic al, input logic rn);
    @(posedge CLOCK_50);
    #1;
    bus.play_req          = pr;
    bus.clip_sel          = cs;
    bus.stop              = st;
    bus.audio_out_allowed = al;
    resetn                = rn;
    @(negedge CLOCK_50);
  endtask

  task automatic nop();
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int passes;
    bus.play_req          = 1'b0;
    bus.clip_sel          = 2'd0;
    bus.stop              = 1'b0;
    bus.audio_out_allowed = 1'b1;

    // Reset state
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_addr",  32'(bus.rom_addr), 0);
    chk("rst_write", 32'(bus.write_audio_out), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_left",  bus.left_channel_audio_out, 0);
    chk("rst_right", bus.right_channel_audio_out, 0);

    // clip_sel=3 is ignored
    cyc(1, 3, 0, 1, 1);
    nop();
    chk("sel3_busy", 32'(bus.busy), 0);
    chk("sel3_addr", 32'(bus.rom_addr), 0);

    // One-shot clip 0: strobes every 4 cycles carrying 1..4
    cyc(1, 0, 0, 1, 1);
    for (int s = 0; s < 4; s++) begin
      nop();
      chk("os_fetch_addr", 32'(bus.rom_addr), 32'(s));
      chk("os_fetch_wr",   32'(bus.write_audio_out), 0);
      nop();
      nop();
      chk("os_push_wr",    32'(bus.write_audio_out), 1);
      chk("os_push_left",  bus.left_channel_audio_out, smp(s + 1));
      nop();
      chk("os_hold_done",  32'(bus.done), (s == 3) ? 32'd1 : 32'd0);
    end
    nop();
`ifdef CLIP_LOOP_EN
    chk("os_loop_busy", 32'(bus.busy), 1);
    chk("os_loop_addr", 32'(bus.rom_addr), 0);
    cyc(0, 0, 1, 1, 1);
    nop();
    chk("os_loop_stop", 32'(bus.busy), 0);
`else
    chk("os_end_busy", 32'(bus.busy), 0);
    chk("os_end_addr", 32'(bus.rom_addr), 3);
    chk("os_end_done", 32'(bus.done), 0);
    chk("os_end_left", bus.left_channel_audio_out, smp(4));
`endif

    // Backpressure: second sample stalled 10 cycles
    cyc(1, 0, 0, 1, 1);
    nop(); nop(); nop();
    chk("bp_s0_wr", 32'(bus.write_audio_out), 1);
    nop();
    nop();
    chk("bp_s1_addr", 32'(bus.rom_addr), 1);
    nop();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0, 1);
      chk("bp_stall_wr",   32'(bus.write_audio_out), 0);
      chk("bp_stall_left", bus.left_channel_audio_out, smp(2));
    end
    cyc(0, 0, 0, 1, 1);
    chk("bp_s1_wr",   32'(bus.write_audio_out), 1);
    chk("bp_s1_left", bus.left_channel_audio_out, smp(2));
    nop();
    chk("bp_hold_wr",   32'(bus.write_audio_out), 0);
    chk("bp_hold_done", 32'(bus.done), 0);
    nop();
    chk("bp_s2_addr", 32'(bus.rom_addr), 2);
    chk("bp_s2_fwr",  32'(bus.write_audio_out), 0);
    nop();
    nop();
    chk("bp_s2_wr",   32'(bus.write_audio_out), 1);
    chk("bp_s2_left", bus.left_channel_audio_out, smp(3));
    cyc(0, 0, 1, 1, 1);
    chk("bp_stop_done", 32'(bus.done), 0);
    nop();
    chk("bp_stop_busy", 32'(bus.busy), 0);
    chk("bp_stop_left", bus.left_channel_audio_out, smp(3));
    nop();
    chk("bp_stop_wr", 32'(bus.write_audio_out), 0);

    // Restart clip 0 while clip 1 sits in PUSH; pending push is discarded
    cyc(1, 1, 0, 1, 1);
    nop();
    chk("rs_c1_addr", 32'(bus.rom_addr), 20);
    nop(); nop();
    chk("rs_c1_left", bus.left_channel_audio_out, smp(21));
    nop();
    nop();
    chk("rs_c1_addr2", 32'(bus.rom_addr), 21);
    nop();
    cyc(1, 0, 0, 1, 1);
    chk("rs_discard_wr", 32'(bus.write_audio_out), 0);
    nop();
    chk("rs_c0_addr", 32'(bus.rom_addr), 0);
    chk("rs_c0_busy", 32'(bus.busy), 1);
    nop();
    nop();
    chk("rs_c0_wr",   32'(bus.write_audio_out), 1);
    chk("rs_c0_left", bus.left_channel_audio_out, smp(1));

    // play_req + stop together: stop wins
    cyc(1, 2, 1, 1, 1);
    chk("pri_done", 32'(bus.done), 0);
    nop();
    chk("pri_busy", 32'(bus.busy), 0);
    chk("pri_addr", 32'(bus.rom_addr), 0);

    // Reset mid-clip while stalled in PUSH
    cyc(1, 1, 0, 1, 1);
    nop(); nop();
    cyc(0, 0, 0, 0, 1);
    chk("mr_pre_left", bus.left_channel_audio_out, smp(21));
    cyc(0, 0, 0, 0, 0);
    nop();
    chk("mr_busy",  32'(bus.busy), 0);
    chk("mr_addr",  32'(bus.rom_addr), 0);
    chk("mr_left",  bus.left_channel_audio_out, 0);
    chk("mr_write", 32'(bus.write_audio_out), 0);
    chk("mr_done",  32'(bus.done), 0);

    // Clip 2 (8..9): one pass, or two passes in the looping build
`ifdef CLIP_LOOP_EN
    passes = 2;
`else
    passes = 1;
`endif
    cyc(1, 2, 0, 1, 1);
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < 2; s++) begin
        nop();
        chk("c2_addr", 32'(bus.rom_addr), 32'(8 + s));
        nop();
        nop();
        chk("c2_wr",   32'(bus.write_audio_out), 1);
        chk("c2_left", bus.left_channel_audio_out, smp(9 + s));
        nop();
        chk("c2_done", 32'(bus.done), (s == 1) ? 32'd1 : 32'd0);
      end
    end
    nop();
`ifdef CLIP_LOOP_EN
    chk("c2_loop_busy", 32'(bus.busy), 1);
    chk("c2_loop_addr", 32'(bus.rom_addr), 8);
    cyc(0, 0, 1, 1, 1);
    nop();
`else
    chk("c2_end_addr", 32'(bus.rom_addr), 9);
`endif
    chk("c2_end_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 6; i++) begin
      nop();
      chk("c2_quiet_wr", 32'(bus.write_audio_out), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
